// File: rtl/ctrl_seq.sv
// Control sequencer: fetches instruction nibbles from program memory, decodes
// them and drives the one-clock control code `cs` plus the immediate `dato`.
module ctrl_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] mem_data,
  output logic [7:0] pc_addr,
  output logic [4:0] cs,
  output logic [3:0] dato,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_EXEC,
    S_JMP_HI,
    S_JMP_LO,
    S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [3:0] ir_q, ir_d;
  logic [3:0] opnd_q, opnd_d;
  logic [3:0] jhi_q, jhi_d;

  function automatic logic [4:0] cs_decode(input logic [3:0] op);
    case (op)
      4'h1:    cs_decode = 5'b10010;
      4'h2:    cs_decode = 5'b11100;
      4'h3:    cs_decode = 5'b11101;
      4'h4:    cs_decode = 5'b10001;
      4'h5:    cs_decode = 5'b10100;
      default: cs_decode = 5'b00000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op >= 4'h7) && (op <= 4'hE);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 4'h0;
      opnd_q  <= 4'h0;
      jhi_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      jhi_q   <= jhi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    jhi_d   = jhi_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = mem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q)
          4'h1, 4'h4: state_d = S_OPER;
          4'h6:       state_d = S_JMP_HI;
          4'hF:       state_d = S_HALT;
          default:    state_d = S_EXEC;
        endcase
      end
      S_OPER: begin
        opnd_d  = mem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_FETCH;
      S_JMP_HI: begin
        jhi_d   = mem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_JMP_LO;
      end
      S_JMP_LO: begin
        pc_d    = {jhi_q, mem_data};
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on mem_data or run.
  always_comb begin
    cs      = 5'b00000;
    illegal = 1'b0;
    if (state_q == S_EXEC) begin
      cs      = cs_decode(ir_q);
      illegal = is_illegal(ir_q);
    end
  end

  assign pc_addr = pc_q;
  assign dato    = opnd_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: two instances, default reset PC and 8'hFE
// for the address-wrap case; each shares a behavioural nibble memory model.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst0, run0, rst1, run1;
  logic [7:0] pc0, pc1;
  logic [4:0] cs0, cs1;
  logic [3:0] dato0, dato1, md0, md1;
  logic       halted0, halted1, ill0, ill1;
  logic [3:0] mem0 [256];
  logic [3:0] mem1 [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign md0 = mem0[pc0];
  assign md1 = mem1[pc1];

  ctrl_seq dut0 (
    .clk(clk), .reset(rst0), .run(run0), .mem_data(md0),
    .pc_addr(pc0), .cs(cs0), .dato(dato0), .halted(halted0), .illegal(ill0)
  );

  ctrl_seq #(.RESET_PC(8'hFE)) dut1 (
    .clk(clk), .reset(rst1), .run(run1), .mem_data(md1),
    .pc_addr(pc1), .cs(cs1), .dato(dato1), .halted(halted1), .illegal(ill1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_mem0();
    for (int i = 0; i < 256; i++) mem0[i] = 4'h0;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    run0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; run0 = 1'b0;
    rst1 = 1'b1; run1 = 1'b0;
    clear_mem0();
    for (int i = 0; i < 256; i++) mem1[i] = 4'h0;
    tick(2);

    // Reset state of both instances
    chk("rst_pc0", pc0, 8'h00);
    chk("rst_pc1", pc1, 8'hFE);
    chk("rst_cs", cs0, 5'b0);
    chk("rst_dato", dato0, 4'h0);
    chk("rst_halt", halted0, 1'b0);
    chk("rst_ill", ill0, 1'b0);

    // Program: LDB A, SVB, RSB, HLT
    mem0[0] = 4'h1; mem0[1] = 4'hA; mem0[2] = 4'h2; mem0[3] = 4'h3; mem0[4] = 4'hF;
    rst0 = 1'b0;
    tick(3);
    chk("idle_pc", pc0, 8'h00);
    chk("idle_cs", cs0, 5'b0);
    run0 = 1'b1;
    tick(1);
    run0 = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      tick(1);
      chk("ldb_pre_cs", cs0, 5'b0);
    end
    tick(1);
    chk("ldb_cs", cs0, 5'b10010);
    chk("ldb_dato", dato0, 4'hA);
    tick(1);
    chk("ldb_one_clk", cs0, 5'b0);
    tick(2);
    chk("svb_cs", cs0, 5'b11100);
    chk("svb_dato", dato0, 4'hA);
    tick(3);
    chk("rsb_cs", cs0, 5'b11101);
    tick(2);
    chk("hlt_pre", halted0, 1'b0);
    tick(1);
    chk("hlt_halted", halted0, 1'b1);
    chk("hlt_pc", pc0, 8'h05);
    run0 = 1'b1;
    tick(3);
    chk("hold_halted", halted0, 1'b1);
    chk("hold_pc", pc0, 8'h05);
    chk("hold_cs", cs0, 5'b0);
    run0 = 1'b0;

    // JMP 0x42 then SVB at the target
    reset0();
    clear_mem0();
    mem0[0] = 4'h6; mem0[1] = 4'h4; mem0[2] = 4'h2; mem0[8'h42] = 4'h2;
    run0 = 1'b1;
    tick(1);
    run0 = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      chk("jmp_cs_quiet", cs0, 5'b0);
    end
    tick(1);
    chk("jmp_target_pc", pc0, 8'h42);
    chk("jmp_target_cs", cs0, 5'b0);
    tick(1);
    chk("jmp_dec_cs", cs0, 5'b0);
    tick(1);
    chk("jmp_svb_cs", cs0, 5'b11100);

    // Illegal opcode 0x9
    reset0();
    clear_mem0();
    mem0[0] = 4'h9;
    run0 = 1'b1;
    tick(1);
    run0 = 1'b0;
    tick(1);
    chk("ill_dec", ill0, 1'b0);
    tick(1);
    chk("ill_pulse", ill0, 1'b1);
    chk("ill_cs", cs0, 5'b0);
    chk("ill_pc", pc0, 8'h01);
    tick(1);
    chk("ill_one_clk", ill0, 1'b0);
    chk("ill_next_pc", pc0, 8'h01);

    // Reset asserted during OPER of the second LDB
    reset0();
    clear_mem0();
    mem0[0] = 4'h1; mem0[1] = 4'hA; mem0[2] = 4'h1; mem0[3] = 4'h7;
    run0 = 1'b1;
    tick(1);
    run0 = 1'b0;
    tick(6);
    chk("oper_pc", pc0, 8'h03);
    chk("oper_dato", dato0, 4'hA);
    rst0 = 1'b1;
    #1;
    chk("arst_pc", pc0, 8'h00);
    chk("arst_dato", dato0, 4'h0);
    chk("arst_cs", cs0, 5'b0);
    chk("arst_halt", halted0, 1'b0);
    @(negedge clk);
    rst0 = 1'b0;
    tick(4);
    chk("post_rst_pc", pc0, 8'h00);
    chk("post_rst_cs", cs0, 5'b0);

    // Wrap across 8'hFF with RESET_PC = 8'hFE
    mem1[8'hFE] = 4'h1; mem1[8'hFF] = 4'h5; mem1[8'h00] = 4'hF;
    rst1 = 1'b0;
    run1 = 1'b1;
    tick(1);
    run1 = 1'b0;
    tick(2);
    chk("wrap_oper_pc", pc1, 8'hFF);
    tick(1);
    chk("wrap_cs", cs1, 5'b10010);
    chk("wrap_dato", dato1, 4'h5);
    chk("wrap_pc", pc1, 8'h00);
    tick(3);
    chk("wrap_halted", halted1, 1'b1);
    chk("wrap_halt_pc", pc1, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
